frame_capture: RTL and testbench
================================

// Module: frame_capture
// PURPOSE
//  Receiving end of the raster coordinate stream: accepts one pixel per handshake in
//  row-major order over a ROW_LIM x COL_LIM tile, tracks the expected (row,col) itself,
//  and writes each pixel into an internal tile buffer at row*COL_LIM+col.
//  Sits between the pixel source/coordinate generator and the image-search matcher,
//  which reads the captured tile back through a 1-cycle read port.
// PARAMETERS
//  COUNT_WIDTH  4   row counter width; col counter is COUNT_WIDTH-1 bits
//  ROW_LIM      9   rows per tile
//  COL_LIM      8   columns per row
//  PIX_WIDTH    8   pixel width
//  ADDR_WIDTH   7   buffer address width; must satisfy 2**ADDR_WIDTH >= ROW_LIM*COL_LIM
// PORTS
//  clk        in   1              clock, all logic on posedge
//  rst        in   1              synchronous, active-high reset
//  start      in   1              pulse: arm a new capture
//  in_valid   in   1              pixel present
//  in_ready   out  1              block accepts pixel
//  in_pixel   in   PIX_WIDTH      pixel data
//  in_row     in   COUNT_WIDTH    source row tag (checked only with COORD_CHECK_EN)
//  in_col     in   COUNT_WIDTH-1  source col tag (checked only with COORD_CHECK_EN)
//  done       out  1              tile complete, level, held in DONE
//  pix_count  out  ADDR_WIDTH     pixels accepted in current capture
//  rd_en      in   1              read request
//  rd_addr    in   ADDR_WIDTH     read address
//  rd_data    out  PIX_WIDTH      read data, valid 1 cycle after rd_en
//  coord_err  out  1              sticky coordinate mismatch flag
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=0, done=0, pix_count=0, exp_row=0, exp_col=0,
//    rd_data=0, coord_err=0. Buffer contents NOT cleared. Reset mid-capture aborts.
//  - FSM IDLE -> CAPTURE on start; CAPTURE -> DONE on acceptance of last pixel;
//    DONE -> CAPTURE on start. start in CAPTURE is ignored.
//  - Entering CAPTURE: exp_row=0, exp_col=0, pix_count=0, done=0, coord_err=0.
//  - in_ready is registered: 1 exactly while state==CAPTURE (first cycle after start).
//  - Transfer = in_valid & in_ready. On transfer: buf[exp_row*COL_LIM+exp_col]<=in_pixel,
//    pix_count+1; exp_col+1, or if exp_col==COL_LIM-1: exp_col=0, exp_row+1.
//  - Last pixel (exp_row==ROW_LIM-1, exp_col==COL_LIM-1): next cycle state=DONE,
//    done=1, in_ready=0, pix_count=ROW_LIM*COL_LIM, exp_row/exp_col wrap to 0.
//  - in_valid while in_ready=0: ignored, nothing written; source must hold data.
//  - Read port live in every state: rd_en -> rd_data=buf[rd_addr] next cycle; rd_data
//    holds otherwise. Same-cycle write and read of one address returns OLD data.
//    rd_addr >= ROW_LIM*COL_LIM returns undefined data (no error).
//  - Address arithmetic in ADDR_WIDTH bits; no truncation for legal parameters.
// CONFIGURATION
//  COORD_CHECK_EN defined: on every transfer compare {in_row,in_col} to
//  {exp_row,exp_col}; mismatch sets coord_err the next cycle, sticky until start
//  into CAPTURE or rst. Pixel still written at the EXPECTED address.
//  COORD_CHECK_EN undefined: in_row/in_col ignored, coord_err tied 0, no compare logic.
// TESTING
//  - rst=1 mid-capture after 10 pixels -> next cycle IDLE, in_ready=0, pix_count=0, done=0.
//  - start, stream 72 pixels value=index, in_valid=1 continuously -> done=1 one cycle
//    after 72nd transfer, pix_count=72; rd_addr=0,8,71 -> rd_data=0,8,71 one cycle later.
//  - Random in_valid gaps (~50%) -> identical buffer contents, done only after 72 transfers.
//  - Pixel index 7 -> exp wraps col 7->0, row 0->1; pixel 8 lands at addr 8.
//  - rd_addr=5 read in same cycle pixel 5 written (old=0xAA, new=0x05) -> rd_data=0xAA;
//    next read -> 0x05.
//  - COORD_CHECK_EN: tag pixel 3 as (0,4) -> coord_err=1 next cycle, stays 1, buf[3]=pixel;
//    start again -> coord_err=0. Without macro, same stimulus -> coord_err=0.

Source files
------------

// File: rtl/frame_capture.sv
// ---------------------------------------------------------------------------
// frame_capture
//
// Receiving end of the raster coordinate stream. Accepts one pixel per
// valid/ready handshake in row-major order over a ROW_LIM x COL_LIM tile. The
// block tracks the expected (row, col) position itself and writes each pixel
// into an internal tile buffer at row*COL_LIM+col. The image-search matcher
// reads the captured tile back through a registered one-cycle read port.
//
// Optional feature (compile-time macro COORD_CHECK_EN):
//   When defined, the source's row/col tags are compared against the expected
//   position on every transfer. A mismatch raises the sticky coord_err flag.
//   When undefined, the tags are ignored and coord_err is tied low.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   start      in   pulse: arm a new capture (ignored while capturing)
//   in_valid   in   pixel present
//   in_ready   out  block accepts a pixel (high exactly while capturing)
//   in_pixel   in   pixel data
//   in_row     in   source row tag (only checked with COORD_CHECK_EN)
//   in_col     in   source col tag (only checked with COORD_CHECK_EN)
//   done       out  tile complete, level, held until the next start
//   pix_count  out  pixels accepted in the current capture
//   rd_en      in   read request
//   rd_addr    in   read address
//   rd_data    out  read data, valid one cycle after rd_en, held otherwise
//   coord_err  out  sticky coordinate mismatch flag
// ---------------------------------------------------------------------------
module frame_capture #(
    parameter int COUNT_WIDTH = 4,
    parameter int ROW_LIM     = 9,
    parameter int COL_LIM     = 8,
    parameter int PIX_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIX_WIDTH-1:0]   in_pixel,
    input  logic [COUNT_WIDTH-1:0] in_row,
    input  logic [COUNT_WIDTH-2:0] in_col,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  pix_count,
    input  logic                   rd_en,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [PIX_WIDTH-1:0]   rd_data,
    output logic                   coord_err
);

    localparam int COL_WIDTH = COUNT_WIDTH - 1;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    localparam logic [COUNT_WIDTH-1:0] ROW_LAST   = COUNT_WIDTH'(ROW_LIM - 1);
    localparam logic [COL_WIDTH-1:0]   COL_LAST   = COL_WIDTH'(COL_LIM - 1);
    localparam logic [COUNT_WIDTH-1:0] ROW_ONE    = COUNT_WIDTH'(1);
    localparam logic [COL_WIDTH-1:0]   COL_ONE    = COL_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]  COL_STRIDE = ADDR_WIDTH'(COL_LIM);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [COUNT_WIDTH-1:0] exp_row;
    logic [COL_WIDTH-1:0]   exp_col;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic                   transfer;
    logic                   last_pixel;
    logic                   start_capture;

    // Sized to the full address space so out-of-tile reads stay in range.
    logic [PIX_WIDTH-1:0] tile_buf [DEPTH];

    assign transfer      = in_valid & in_ready;
    assign last_pixel    = (exp_row == ROW_LAST) && (exp_col == COL_LAST);
    // A start while capturing is ignored, so only IDLE/DONE re-arm.
    assign start_capture = start && (state != CAPTURE);
    assign wr_addr       = ADDR_WIDTH'(exp_row) * COL_STRIDE + ADDR_WIDTH'(exp_col);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CAPTURE;
            CAPTURE: if (transfer && last_pixel) state_next = DONE;
            DONE:    if (start) state_next = CAPTURE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the registered state, so in_ready is glitch-free
    // and rises on the first cycle after start.
    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        case (state)
            CAPTURE: in_ready = 1'b1;
            DONE:    done     = 1'b1;
            default: ;
        endcase
    end

    // Expected-position tracking and accepted-pixel count. The position wraps
    // back to (0,0) after the last pixel while pix_count holds the tile size.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_row   <= '0;
            exp_col   <= '0;
            pix_count <= '0;
        end else if (start_capture) begin
            exp_row   <= '0;
            exp_col   <= '0;
            pix_count <= '0;
        end else if (transfer) begin
            pix_count <= pix_count + ADDR_ONE;
            if (last_pixel) begin
                exp_row <= '0;
                exp_col <= '0;
            end else if (exp_col == COL_LAST) begin
                exp_col <= '0;
                exp_row <= exp_row + ROW_ONE;
            end else begin
                exp_col <= exp_col + COL_ONE;
            end
        end
    end

    // Tile buffer write; contents survive reset. The write is suppressed
    // during reset so an aborted capture cannot land a stray pixel.
    always_ff @(posedge clk) begin
        if (transfer && !rst) begin
            tile_buf[wr_addr] <= in_pixel;
        end
    end

    // Read port: a same-cycle write to the same address returns the old
    // contents because both use non-blocking updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= tile_buf[rd_addr];
        end
    end

`ifdef COORD_CHECK_EN
    // The pixel is still written at the expected address on a mismatch; only
    // the flag records that the source disagreed.
    always_ff @(posedge clk) begin
        if (rst) begin
            coord_err <= 1'b0;
        end else if (start_capture) begin
            coord_err <= 1'b0;
        end else if (transfer && ({in_row, in_col} != {exp_row, exp_col})) begin
            coord_err <= 1'b1;
        end
    end
`else
    // Tags are not checked in this build.
    logic unused_tags;
    assign unused_tags = ^{in_row, in_col};
    assign coord_err   = 1'b0;
`endif

endmodule

// File: tb/tb_frame_capture.sv
// ---------------------------------------------------------------------------
// tb_frame_capture
//
// Self-checking bench for frame_capture. Read-back expectations live in a
// table of {address, expected data, phase} records; the multi-cycle corner
// cases (abort by reset, same-cycle read/write, ignored start, coordinate
// tag error) are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_frame_capture;

    localparam int TILE = 72;

`ifdef COORD_CHECK_EN
    localparam logic EXP_CERR = 1'b1;
`else
    localparam logic EXP_CERR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pixel;
    logic [3:0] in_row;
    logic [2:0] in_col;
    logic       done;
    logic [6:0] pix_count;
    logic       rd_en;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       coord_err;

    int testsRun  = 0;
    int testsFail = 0;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] expData;
        int         phase;
    } readVec_t;

    readVec_t vecs [11];

    frame_capture dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_row    (in_row),
        .in_col    (in_col),
        .done      (done),
        .pix_count (pix_count),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .coord_err (coord_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one read and compare the data returned one cycle later.
    task automatic applyStimulus(input string name, input logic [6:0] addr, input logic [7:0] exp);
        rd_en   = 1'b1;
        rd_addr = addr;
        tick();
        rd_en   = 1'b0;
        checkOutput(name, rd_data, exp);
    endtask

    task automatic doStart();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("startReady", in_ready, 1'b1);
        checkOutput("startCount", pix_count, 7'd0);
        checkOutput("startDone", done, 1'b0);
        checkOutput("startCoordErr", coord_err, 1'b0);
    endtask

    // Stream one full tile of pixels base+index. readAt issues a same-cycle
    // read of that pixel's address; tagErrIdx mis-tags that pixel as (0,4);
    // startMid pulses start partway through, which must be ignored.
    task automatic streamTile(input bit gaps, input logic [7:0] base, input int readAt,
                              input int tagErrIdx, input bit startMid);
        int  i      = 0;
        int  cycles = 0;
        bit  early  = 1'b0;
        bit  pulsed = 1'b0;
        bit  xfer;
        while (i < TILE && cycles < 1000) begin
            if (gaps && ($urandom_range(0, 1) == 0)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_pixel = 8'(base + i);
                in_row   = 4'(i / 8);
                in_col   = 3'(i % 8);
                if (i == tagErrIdx) begin
                    in_row = 4'd0;
                    in_col = 3'd4;
                end
            end
            rd_en   = (i == readAt) && in_valid;
            rd_addr = 7'(readAt);
            if (startMid && !pulsed && i == 30) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            xfer = in_valid && in_ready;
            tick();
            start = 1'b0;
            rd_en = 1'b0;
            cycles++;
            if (xfer) begin
                if (i == readAt) checkOutput("sameCycleReadOld", rd_data, 8'hAA);
                if (i == tagErrIdx) checkOutput("coordErrSet", coord_err, EXP_CERR);
                i++;
                if (i < TILE && done) early = 1'b1;
            end
        end
        in_valid = 1'b0;
        checkOutput("streamBudget", i, TILE);
        checkOutput("noEarlyDone", early, 1'b0);
        checkOutput("tileDone", done, 1'b1);
        checkOutput("tileCount", pix_count, 7'd72);
        checkOutput("tileReadyLow", in_ready, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{7'd0,  8'h00, 0};
        vecs[1]  = '{7'd8,  8'h08, 0};
        vecs[2]  = '{7'd71, 8'h47, 0};
        vecs[3]  = '{7'd5,  8'h05, 0};
        vecs[4]  = '{7'd7,  8'h07, 0};
        vecs[5]  = '{7'd9,  8'h09, 0};
        vecs[6]  = '{7'd0,  8'h80, 1};
        vecs[7]  = '{7'd8,  8'h88, 1};
        vecs[8]  = '{7'd71, 8'hC7, 1};
        vecs[9]  = '{7'd36, 8'hA4, 1};
        vecs[10] = '{7'd64, 8'hC0, 1};

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        in_row   = '0;
        in_col   = '0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("resetReady", in_ready, 1'b0);
        checkOutput("resetDone", done, 1'b0);
        checkOutput("resetCount", pix_count, 7'd0);
        checkOutput("resetRdData", rd_data, 8'h00);
        checkOutput("resetCoordErr", coord_err, 1'b0);

        // Abort a capture with reset after 10 pixels of 0xAA.
        doStart();
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_pixel = 8'hAA;
            in_row   = 4'(k / 8);
            in_col   = 3'(k % 8);
            tick();
        end
        in_valid = 1'b0;
        checkOutput("abortCountBefore", pix_count, 7'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abortReady", in_ready, 1'b0);
        checkOutput("abortCount", pix_count, 7'd0);
        checkOutput("abortDone", done, 1'b0);

        // Continuous capture, reading address 5 as pixel 5 is written.
        doStart();
        streamTile(1'b0, 8'h00, 5, -1, 1'b0);
        checkOutput("tileCoordErr", coord_err, 1'b0);

        // in_valid while not ready must change nothing.
        in_valid = 1'b1;
        in_pixel = 8'h33;
        for (int k = 0; k < 3; k++) tick();
        in_valid = 1'b0;
        checkOutput("ignoredCount", pix_count, 7'd72);
        checkOutput("ignoredDone", done, 1'b1);

        for (int v = 0; v < 11; v++) begin
            if (vecs[v].phase == 0) applyStimulus($sformatf("read0_addr%0d", vecs[v].addr), vecs[v].addr, vecs[v].expData);
        end
        rd_addr = 7'd20;
        tick();
        checkOutput("rdDataHold", rd_data, 8'h09);

        // Capture with random gaps and an ignored mid-capture start.
        doStart();
        streamTile(1'b1, 8'h80, -1, -1, 1'b1);
        for (int v = 0; v < 11; v++) begin
            if (vecs[v].phase == 1) applyStimulus($sformatf("read1_addr%0d", vecs[v].addr), vecs[v].addr, vecs[v].expData);
        end

        // Coordinate tag error on pixel 3.
        doStart();
        streamTile(1'b0, 8'h40, -1, 3, 1'b0);
        checkOutput("coordErrSticky", coord_err, EXP_CERR);
        applyStimulus("coordPixelAddr3", 7'd3, 8'h43);
        doStart();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
